instr_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the ID stage of the 32-bit pipeline.
- Issues word reads to instruction memory and buffers returned words with their next-PC in an in-order queue.
- Presents one {IR, NPC} pair per cycle to decode under a valid/ready handshake.
- Taken-branch redirects flush the queue and discard stale in-flight responses; halt stops new fetches.

---
 rtl/pf_pkg.sv | 34 +++
 rtl/instr_prefetch_queue_if.sv | 28 ++
 rtl/pf_fifo.sv | 51 +++++
 rtl/instr_prefetch_queue.sv | 105 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pf_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package pf_pkg;

  localparam int unsigned PF_ADDR_W = 10;
  localparam int unsigned PF_DATA_W = 32;

  typedef struct packed {
    logic [PF_DATA_W-1:0] ir;
    logic [PF_ADDR_W-1:0] npc;
  } pf_entry_t;

  // Opcode field (ir[31:26]) values shared with the pipeline.
  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_SLT   = 6'd4,
    OP_MUL   = 6'd5,
    OP_LW    = 6'd8,
    OP_SW    = 6'd9,
    OP_ADDI  = 6'd10,
    OP_SUBI  = 6'd11,
    OP_SLTI  = 6'd12,
    OP_BNEQZ = 6'd13,
    OP_BEQZ  = 6'd14,
    OP_HLT   = 6'd63
  } pf_opcode_e;

  function automatic logic pf_is_branch(input logic [5:0] op);
    return (op == OP_BEQZ) || (op == OP_BNEQZ);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Memory-side and decode-side signals of the prefetch queue.
interface instr_prefetch_queue_if #(
  parameter int unsigned ADDR_W = pf_pkg::PF_ADDR_W,
  parameter int unsigned DATA_W = pf_pkg::PF_DATA_W
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              id_valid;
  logic [DATA_W-1:0] id_ir;
  logic [ADDR_W-1:0] id_npc;
  logic              id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_ir, id_npc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_ir, id_npc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, id_ready
  );
endinterface

// File: rtl/pf_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from storage.
module pf_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: credit-limited word reads, in-order {IR, NPC}
// queue to decode, redirect flush with stale-response discard, halt gating.
module instr_prefetch_queue
  import pf_pkg::*;
#(
  parameter int unsigned       ADDR_W   = PF_ADDR_W,
  parameter int unsigned       DATA_W   = PF_DATA_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk1,
  input  logic                   rst,
  instr_prefetch_queue_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]        pc;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         discard;
  logic [CNT_W-1:0]         q_count;
  logic [CNT_W-1:0]         t_count;
  logic [CNT_W:0]           in_use;
  logic                     credit_ok;
  logic                     grant;
  logic                     rsp_keep;
  logic                     rsp_drop;
  logic                     q_push;
  logic                     q_pop;
  logic                     q_full;
  logic                     q_empty;
  logic                     t_full;
  logic                     t_empty;
  logic [ADDR_W-1:0]        tag_head;
  logic [DATA_W+ADDR_W-1:0] q_head;

  assign in_use    = {1'b0, q_count} + {1'b0, outstanding};
  assign credit_ok = (in_use < (CNT_W + 1)'(DEPTH));
  assign grant     = bus.imem_req && bus.imem_gnt;
  assign rsp_keep  = bus.imem_rvalid && (discard == '0);
  assign rsp_drop  = bus.imem_rvalid && (discard != '0);
  assign q_push    = rsp_keep;
  assign q_pop     = bus.id_valid && bus.id_ready;

  assign bus.imem_req  = !rst && credit_ok && !bus.halt && !bus.redirect_valid;
  assign bus.imem_addr = pc;
  assign bus.id_valid  = !q_empty;
  assign {bus.id_ir, bus.id_npc} = q_head;

  pf_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .push      (grant),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (bus.redirect_valid),
    .head      (tag_head),
    .count     (t_count),
    .full      (t_full),
    .empty     (t_empty)
  );

  pf_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .push      (q_push),
    .push_data ({bus.imem_rdata, tag_head + 1'b1}),
    .pop       (q_pop),
    .flush     (bus.redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(bus.imem_rvalid);
      if (bus.redirect_valid) begin
        pc      <= bus.redirect_pc;
        // No grant in a redirect cycle, so everything still in flight after
        // this edge (including earlier stale ones) becomes stale.
        discard <= outstanding - CNT_W'(bus.imem_rvalid);
      end else begin
        if (grant)    pc      <= pc + 1'b1;
        if (rsp_drop) discard <= discard - 1'b1;
      end
    end
  end

  a_no_queue_overflow: assert property (@(posedge clk1) disable iff (rst) !(q_push && q_full));
  a_no_tag_overflow:   assert property (@(posedge clk1) disable iff (rst) !(grant && t_full));
  a_tag_for_response:  assert property (@(posedge clk1) disable iff (rst) rsp_keep |-> !t_empty);
  a_tag_accounting:    assert property (@(posedge clk1) disable iff (rst) t_count == outstanding - discard);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a 1..3-cycle latency memory.
module tb_instr_prefetch_queue;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  instr_prefetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_prefetch_queue #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (4),
    .RESET_PC (10'h000)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned lat   = 1;
  int          gnt_cnt;
  logic [2:0]  pv;
  logic [AW-1:0] pa [3];

  // Memory model: mem[k] = 0x1000_0000 + k, fixed latency 'lat' after grant.
  always @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pv      <= '0;
      gnt_cnt <= 0;
    end else begin
      pv    <= {pv[1:0], bus.imem_req && bus.imem_gnt};
      pa[0] <= bus.imem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      if (bus.imem_req && bus.imem_gnt) gnt_cnt <= gnt_cnt + 1;
    end
  end

  always_comb begin
    case (lat)
      2: begin
        bus.imem_rvalid = pv[1];
        bus.imem_rdata  = 32'h1000_0000 + {22'b0, pa[1]};
      end
      3: begin
        bus.imem_rvalid = pv[2];
        bus.imem_rdata  = 32'h1000_0000 + {22'b0, pa[2]};
      end
      default: begin
        bus.imem_rvalid = pv[0];
        bus.imem_rdata  = 32'h1000_0000 + {22'b0, pa[0]};
      end
    endcase
  end

  function automatic logic [31:0] word(input int unsigned a);
    return 32'h1000_0000 + (a & 32'h3FF);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic consume(input int unsigned n, input int unsigned start);
    bus.id_ready = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned budget;
      budget = 0;
      while (!bus.id_valid && budget < 50) begin
        @(negedge clk1);
        budget++;
      end
      if (!bus.id_valid) begin
        check("consume_timeout", 32'(bus.id_valid), 32'd1);
        return;
      end
      check("id_ir", bus.id_ir, word(start + i));
      check("id_npc", 32'(bus.id_npc), (start + i + 1) & 32'h3FF);
      @(negedge clk1);
    end
  endtask

  task automatic do_reset(input int unsigned lat_v, input logic ready);
    rst                = 1'b1;
    lat                = lat_v;
    bus.id_ready       = ready;
    bus.redirect_valid = 1'b0;
    bus.halt           = 1'b0;
    bus.imem_gnt       = 1'b1;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.imem_gnt       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    bus.id_ready       = 1'b1;
    repeat (3) @(negedge clk1);

    // reset state and steady stream
    check("rst_id_valid",  32'(bus.id_valid),  32'd0);
    check("rst_imem_req",  32'(bus.imem_req),  32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_id_ir",     bus.id_ir,          32'd0);
    check("rst_id_npc",    32'(bus.id_npc),    32'd0);
    rst = 1'b0;
    #1 check("t1_req_after_rst", 32'(bus.imem_req), 32'd1);
    @(negedge clk1);
    check("t1_valid_c1", 32'(bus.id_valid),  32'd0);
    check("t1_addr_c1",  32'(bus.imem_addr), 32'd1);
    @(negedge clk1);
    check("t1_valid_c2", 32'(bus.id_valid), 32'd1);
    consume(8, 0);

    // backpressure: queue fills to 4, then drains in order
    do_reset(1, 1'b0);
    repeat (10) @(negedge clk1);
    check("t2_gnt_cnt",  32'(gnt_cnt),        32'd4);
    check("t2_req_off",  32'(bus.imem_req),   32'd0);
    check("t2_valid",    32'(bus.id_valid),   32'd1);
    check("t2_head_ir",  bus.id_ir,           word(0));
    check("t2_head_npc", 32'(bus.id_npc),     32'd1);
    consume(8, 0);

    // redirect with two requests in flight, no response yet
    do_reset(3, 1'b1);
    repeat (2) @(negedge clk1);
    check("t3_gnt_cnt", 32'(gnt_cnt), 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h200;
    #1 check("t3_req_in_redirect", 32'(bus.imem_req), 32'd0);
    @(negedge clk1);
    bus.redirect_valid = 1'b0;
    check("t3_empty_after", 32'(bus.id_valid), 32'd0);
    consume(4, 32'h200);

    // redirect together with a response and a pop on the same edge
    do_reset(2, 1'b1);
    repeat (4) @(negedge clk1);
    check("t4_pre_valid",  32'(bus.id_valid),    32'd1);
    check("t4_pre_rvalid", 32'(bus.imem_rvalid), 32'd1);
    check("t4_pre_head",   bus.id_ir,            word(1));
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h100;
    @(negedge clk1);
    bus.redirect_valid = 1'b0;
    check("t4_empty_after", 32'(bus.id_valid), 32'd0);
    consume(4, 32'h100);

    // halt with 3 queued and 1 outstanding
    do_reset(1, 1'b0);
    repeat (4) @(negedge clk1);
    check("t5_pre_valid", 32'(bus.id_valid), 32'd1);
    check("t5_pre_gnt",   32'(gnt_cnt),      32'd4);
    bus.halt = 1'b1;
    consume(4, 0);
    repeat (3) @(negedge clk1);
    check("t5_halt_req",   32'(bus.imem_req),  32'd0);
    check("t5_halt_empty", 32'(bus.id_valid),  32'd0);
    check("t5_halt_gnt",   32'(gnt_cnt),       32'd4);
    bus.halt = 1'b0;
    #1;
    check("t5_resume_req",  32'(bus.imem_req),  32'd1);
    check("t5_resume_addr", 32'(bus.imem_addr), 32'd4);
    consume(3, 4);

    // address wrap, then asynchronous reset mid-burst
    do_reset(1, 1'b1);
    @(negedge clk1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h3FE;
    @(negedge clk1);
    bus.redirect_valid = 1'b0;
    consume(5, 32'h3FE);
    check("t6_pre_valid", 32'(bus.id_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.id_valid),  32'd0);
    check("t6_rst_req",   32'(bus.imem_req),  32'd0);
    check("t6_rst_addr",  32'(bus.imem_addr), 32'd0);
    check("t6_rst_ir",    bus.id_ir,          32'd0);
    @(negedge clk1);
    rst = 1'b0;
    consume(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
